// File: rtl/ecap5_dwbgpio_pkg.sv
// Shared register map definitions for the ecap5_dwbgpio Wishbone GPIO block.
// Word offsets are taken from byte address bits [3:2].
package ecap5_dwbgpio_pkg;

    typedef logic [1:0] gpio_reg_idx_t;

    localparam gpio_reg_idx_t GPIO_OUT  = 2'd0;
    localparam gpio_reg_idx_t GPIO_IN   = 2'd1;
    localparam gpio_reg_idx_t GPIO_EDGE = 2'd2;
    localparam gpio_reg_idx_t GPIO_IEN  = 2'd3;

    localparam int GPIO_DATA_W = 32;

    // Word index of a byte address; higher address bits alias onto the same four registers.
    function automatic gpio_reg_idx_t gpio_reg_idx(input logic [3:2] adr);
        return gpio_reg_idx_t'(adr);
    endfunction

endpackage

// File: rtl/ecap5_dwbgpio_debounce.sv
// One input bit: 2-FF synchroniser followed by a stability filter.
// The counting filter exists only when GPIO_DEBOUNCE_EN is defined; otherwise the output is one register after the synchroniser.
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level
);

    logic sync1_reg;
    logic sync2_reg;
    logic stable_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= pin;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             stable_next;

    // Any cycle where the synchronised input agrees with the accepted value restarts the count.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (sync2_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = sync2_reg;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            stable_reg <= stable_next;
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_reg <= 1'b0;
        end else begin
            stable_reg <= sync2_reg;
        end
    end
`endif

    assign level = stable_reg;

endmodule

// File: rtl/ecap5_dwbgpio.sv
// Wishbone B4 pipelined GPIO slave: OUT/IN/EDGE/IEN registers, sticky rising-edge flags and a level irq.
// Input filtering is selected by the GPIO_DEBOUNCE_EN macro (see gpio_debounce).
module ecap5_dwbgpio
    import ecap5_dwbgpio_pkg::*;
#(
    parameter int NB_OUT          = 2,
    parameter int NB_IN           = 2,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    output logic              wb_ack_o,
    output logic              wb_stall_o,
    output logic [NB_OUT-1:0] gpio_o,
    input  logic [NB_IN-1:0]  gpio_i,
    output logic              irq_o
);

    logic                   accept;
    logic                   wr_en;
    gpio_reg_idx_t          reg_idx;
    logic [GPIO_DATA_W-1:0] rdata;

    logic                   ack_reg;
    logic [GPIO_DATA_W-1:0] dat_reg;
    logic [NB_OUT-1:0]      out_reg;
    logic [NB_IN-1:0]       ien_reg;
    logic [NB_IN-1:0]       edge_reg;
    logic [NB_IN-1:0]       edge_next;
    logic [NB_IN-1:0]       in_prev_reg;
    logic [NB_IN-1:0]       in_val;
    logic [NB_IN-1:0]       w1c_mask;
    logic                   irq_reg;

    logic unused_bits;
    assign unused_bits = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i};

    assign accept  = wb_cyc_i & wb_stb_i;
    assign wr_en   = accept & wb_we_i & wb_sel_i[0];
    assign reg_idx = gpio_reg_idx(wb_adr_i[3:2]);

    genvar gi;
    generate
        for (gi = 0; gi < NB_IN; gi++) begin : g_in
            gpio_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_filter (
                .clk   (clk_i),
                .rst_n (rst_i),
                .pin   (gpio_i[gi]),
                .level (in_val[gi])
            );
        end
    endgenerate

    always_comb begin
        rdata = '0;
        case (reg_idx)
            GPIO_OUT:  rdata[NB_OUT-1:0] = out_reg;
            GPIO_IN:   rdata[NB_IN-1:0]  = in_val;
            GPIO_EDGE: rdata[NB_IN-1:0]  = edge_reg;
            GPIO_IEN:  rdata[NB_IN-1:0]  = ien_reg;
            default:   rdata = '0;
        endcase
    end

    // New rising edges are ORed in after the clear, so a same-cycle set wins over W1C.
    always_comb begin
        w1c_mask = '0;
        if (wr_en && reg_idx == GPIO_EDGE) begin
            w1c_mask = wb_dat_i[NB_IN-1:0];
        end
        edge_next = (edge_reg & ~w1c_mask) | (in_val & ~in_prev_reg);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_reg <= 1'b0;
            dat_reg <= '0;
        end else begin
            ack_reg <= accept;
            dat_reg <= accept ? rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_reg     <= '0;
            ien_reg     <= '0;
            edge_reg    <= '0;
            in_prev_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            if (wr_en && reg_idx == GPIO_OUT) begin
                out_reg <= wb_dat_i[NB_OUT-1:0];
            end
            if (wr_en && reg_idx == GPIO_IEN) begin
                ien_reg <= wb_dat_i[NB_IN-1:0];
            end
            edge_reg    <= edge_next;
            in_prev_reg <= in_val;
            irq_reg     <= |(edge_reg & ien_reg);
        end
    end

    assign wb_ack_o   = ack_reg;
    assign wb_dat_o   = dat_reg;
    assign wb_stall_o = 1'b0;
    assign gpio_o     = out_reg;
    assign irq_o      = irq_reg;

endmodule
